// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and encodings for the programmable clock divider
package clk_div_pkg;

  // Default width of the ratio and period counter
  localparam int CNT_W_DEFAULT = 8;

  // Default ratio after reset
  localparam int DEF_DIV_DEFAULT = 2;

  // Smallest ratio the divider can realise (one cycle high, one low)
  localparam int MIN_DIV = 2;

  // Encoding of the div_err flag that accompanies div_ack
  typedef enum logic {
    DIV_ERR_NONE    = 1'b0,
    DIV_ERR_INVALID = 1'b1
  } div_err_e;

endpackage

// File: rtl/clk_div_odd_ext.sv
// rtl/clk_div_odd_ext.sv - negedge half-cycle extension that squares up odd-ratio duty
module clk_div_odd_ext (
  input  logic clk_in,
  input  logic rst_n,
  input  logic odd_en,
  input  logic clk_pos,
  output logic clk_out
);

  logic ext_q;

  // Follow the posedge phase half a cycle late so the OR falls on a negedge
  always_ff @(negedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      ext_q <= 1'b0;
    end else begin
      ext_q <= clk_pos & odd_en;
    end
  end

  // ext_q is still high when clk_pos falls, so the OR cannot glitch low
  assign clk_out = clk_pos | ext_q;

endmodule

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - runtime-programmable integer clock divider with glitch-free ratio change (optional ODD_DUTY50_EN)
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEFAULT,
  parameter int DEF_DIV = DEF_DIV_DEFAULT
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             div_req,
  input  logic [CNT_W-1:0] div_val,
  output logic             div_ack,
  output logic             div_err,
  output logic [CNT_W-1:0] cur_div,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] n_next;
  logic             boundary;
  logic             req_take;
  logic             req_valid;
  logic             apply_req;
  logic             clk_pos;
  logic             clk_pos_next;

  // Boundary detection, request qualification and next-state of the period counter
  always_comb begin
    boundary     = (cnt == (cur_div - CNT_W'(1)));
    req_take     = div_req && !div_ack;
    req_valid    = (div_val >= CNT_W'(MIN_DIV));
    apply_req    = req_take && req_valid && boundary;
    n_next       = apply_req ? div_val : cur_div;
    cnt_next     = boundary ? '0 : (cnt + CNT_W'(1));
    clk_pos_next = (cnt_next < (n_next >> 1));
  end

  // Counter, active ratio, handshake and posedge clock phase
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= CNT_W'(DEF_DIV - 1);
      cur_div <= CNT_W'(DEF_DIV);
      clk_pos <= 1'b0;
      tick    <= 1'b0;
      div_ack <= 1'b0;
      div_err <= DIV_ERR_NONE;
    end else begin
      cnt     <= cnt_next;
      cur_div <= n_next;
      clk_pos <= clk_pos_next;
      tick    <= boundary;
      div_ack <= apply_req || (req_take && !req_valid);
      div_err <= (req_take && !req_valid) ? DIV_ERR_INVALID : DIV_ERR_NONE;
    end
  end

`ifdef ODD_DUTY50_EN
  clk_div_odd_ext u_odd_ext (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .odd_en  (cur_div[0]),
    .clk_pos (clk_pos),
    .clk_out (clk_out)
  );
`else
  assign clk_out = clk_pos;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - self-checking bench for clk_div_prog against a period/phase reference model
module tb_clk_div_prog;

  localparam int CNT_W = 8;
  localparam int DEF   = 2;

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic             div_req;
  logic [CNT_W-1:0] div_val;
  logic             div_ack;
  logic             div_err;
  logic [CNT_W-1:0] cur_div;
  logic             clk_out;
  logic             tick;

  int errors = 0;
  int checks = 0;

  // Reference model: edge index, start edge of current period, ratio
  int k;
  int m_start;
  int m_n;
  int pos;
  bit e_ack;
  bit e_err;
  bit e_tick;
  bit e_out;
  bit m_ext;

  always #5 clk_in = ~clk_in;

  clk_div_prog #(.CNT_W(CNT_W), .DEF_DIV(DEF)) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .div_req (div_req),
    .div_val (div_val),
    .div_ack (div_ack),
    .div_err (div_err),
    .cur_div (cur_div),
    .clk_out (clk_out),
    .tick    (tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    k       = 0;
    m_start = 1;
    m_n     = DEF;
    e_ack   = 1'b0;
    m_ext   = 1'b0;
  endtask

  // One posedge: advance the model from the driven inputs, then compare
  task automatic step();
    bit take;
    bit bnd;
    @(posedge clk_in);
    #1;
    k++;
    bnd   = (((k - m_start) % m_n) == 0);
    take  = div_req && !e_ack;
    e_ack = 1'b0;
    e_err = 1'b0;
    if (take && (int'(div_val) < 2)) begin
      e_ack = 1'b1;
      e_err = 1'b1;
    end else if (take && bnd) begin
      m_n     = int'(div_val);
      m_start = k;
      e_ack   = 1'b1;
    end
    pos    = (k - m_start) % m_n;
    e_tick = (pos == 0);
    e_out  = (pos < (m_n / 2));
`ifdef ODD_DUTY50_EN
    e_out  = e_out || m_ext;
    m_ext  = (pos < (m_n / 2)) && ((m_n % 2) == 1);
`endif
    chk("clk_out", 32'(clk_out), 32'(e_out));
    chk("tick", 32'(tick), 32'(e_tick));
    chk("div_ack", 32'(div_ack), 32'(e_ack));
    chk("div_err", 32'(div_err), 32'(e_err));
    chk("cur_div", 32'(cur_div), 32'(m_n));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Raise a request, hold it through the ack cycle, then drop it
  task automatic do_req(input logic [CNT_W-1:0] v, output int lat);
    int n;
    div_req = 1'b1;
    div_val = v;
    n = 0;
    do begin
      step();
      n++;
    end while (!e_ack && n < 400);
    lat = n;
    checks++;
    assert (e_ack) else begin
      errors++;
      $error("FAIL req_timeout observed=0 expected=1");
    end
    step();
    div_req = 1'b0;
  endtask

  initial begin
    int lat;
    int idle;
    logic [CNT_W-1:0] rv;

    rst_n   = 1'b0;
    div_req = 1'b0;
    div_val = '0;
    model_reset();

    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_clk_out", 32'(clk_out), 32'(0));
    chk("rst_tick", 32'(tick), 32'(0));
    chk("rst_ack", 32'(div_ack), 32'(0));
    chk("rst_err", 32'(div_err), 32'(0));
    chk("rst_cur_div", 32'(cur_div), 32'(DEF));

    @(negedge clk_in);
    rst_n = 1'b1;
    run(6);

    // Ratio 4 requested mid-period, then 3, then invalid 1 and 0
    do_req(8'd4, lat);
    run(9);
    step();
    do_req(8'd3, lat);
    run(9);
    do_req(8'd1, lat);
    chk("inv1_latency", 32'(lat), 32'(1));
    run(4);
    do_req(8'd0, lat);
    chk("inv0_latency", 32'(lat), 32'(1));
    run(6);

    // Request raised so that the very next edge is a boundary
    for (int i = 0; i < 300 && (((k + 1 - m_start) % m_n) != 0); i++) step();
    do_req(8'd5, lat);
    chk("bnd_latency", 32'(lat), 32'(1));
    run(7);

    // Randomised ratios, invalid values and request timing
    for (int it = 0; it < 14; it++) begin
      idle = int'($urandom_range(0, 6));
      run(idle);
      if ($urandom_range(0, 4) == 0) rv = 8'($urandom_range(0, 1));
      else rv = 8'($urandom_range(2, 12));
      do_req(rv, lat);
      run(int'($urandom_range(1, 8)));
    end

    // Largest ratio, then asynchronous reset at cnt=100 with a request pending
    do_req(8'd255, lat);
    run(255);
    for (int i = 0; i < 300 && pos != 98; i++) step();
    div_req = 1'b1;
    div_val = 8'd9;
    run(2);
    chk("pre_rst_pos", 32'(pos), 32'(100));
    chk("pre_rst_clk_out", 32'(clk_out), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_clk_out", 32'(clk_out), 32'(0));
    chk("async_tick", 32'(tick), 32'(0));
    chk("async_cur_div", 32'(cur_div), 32'(DEF));
    div_req = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    model_reset();
    rst_n = 1'b1;
    run(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
